// File: rtl/pdl_pkg.sv
// Shared constants, operation encoding and pointer helpers for the PDL stack.
// Optional bounds checking is enabled in pdl_stack by defining PDL_BOUNDS_CHECK_EN.
package pdl_pkg;

  localparam int unsigned PDL_DATA_WIDTH = 32;
  localparam int unsigned PDL_ADDR_WIDTH = 10;

  // Pointer helpers work on a wide word and are masked to the real width.
  localparam int unsigned PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Which kind of access the current cycle performs, after priority resolution.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_INDEXED
  } op_e;

  function automatic ptr_word_t ptr_mask(input int unsigned aw);
    ptr_word_t m;
    if (aw >= PTR_MAX_W) m = '1;
    else m = (ptr_word_t'(1) << aw) - ptr_word_t'(1);
    return m;
  endfunction

  // Increment modulo 2**aw.
  function automatic ptr_word_t ptr_inc(input ptr_word_t p, input int unsigned aw);
    return (p + ptr_word_t'(1)) & ptr_mask(aw);
  endfunction

  // Decrement modulo 2**aw.
  function automatic ptr_word_t ptr_dec(input ptr_word_t p, input int unsigned aw);
    return (p - ptr_word_t'(1)) & ptr_mask(aw);
  endfunction

  // Stack operations always win over indexed access; push+pop replaces the top.
  function automatic op_e decode_op(input logic push, input logic pop,
                                    input logic rd, input logic wr);
    op_e op;
    if (push && pop) op = OP_REPLACE;
    else if (push)   op = OP_PUSH;
    else if (pop)    op = OP_POP;
    else if (rd || wr) op = OP_INDEXED;
    else op = OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/pdl_ram.sv
// Synchronous single-port storage for the PDL stack, no reset.
// A read in the same cycle as a write returns the written data, except when
// rd_old is set, which returns the previous contents (used for top replace).
module pdl_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic                  rd_old,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single address port: write when we, update read register only when re.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= (we && !rd_old) ? wdata : mem[addr];
  end

endmodule

// File: rtl/pdl_stack.sv
// Push-down list stack with indexed access and one-cycle read latency.
// Define PDL_BOUNDS_CHECK_EN to enable sticky overflow/underflow flags;
// otherwise both flags are tied to zero and the pointer simply wraps.
module pdl_stack
  import pdl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PDL_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PDL_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] l,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic                  ptr_ld,
  input  logic [ADDR_WIDTH-1:0] ptr_din,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] pdlo,
  output logic                  pdlo_valid,
  output logic [ADDR_WIDTH-1:0] pdl_ptr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] PTR_TOP = '1;

  op_e                   op;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_nxt;
  logic [ADDR_WIDTH-1:0] ptr_up;
  logic [ADDR_WIDTH-1:0] ptr_dn;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;
  logic                  ram_re;
  logic                  ram_rd_old;
  logic                  valid_q;
  logic                  zero_q;
  logic                  ovf_hit;
  logic                  unf_hit;

  assign ptr_up = ADDR_WIDTH'(ptr_inc(ptr_word_t'(ptr_q), ADDR_WIDTH));
  assign ptr_dn = ADDR_WIDTH'(ptr_dec(ptr_word_t'(ptr_q), ADDR_WIDTH));

  // Resolve the cycle's operation into one RAM access and the next pointer.
  always_comb begin
    op         = reset ? decode_op(push, pop, rd, wr) : OP_IDLE;
    ram_addr   = ptr_q;
    ram_wdata  = l;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_rd_old = 1'b0;
    ptr_nxt    = ptr_q;
    ovf_hit    = 1'b0;
    unf_hit    = 1'b0;
    unique case (op)
      OP_REPLACE: begin
        ram_we     = 1'b1;
        ram_re     = 1'b1;
        ram_rd_old = 1'b1;
      end
      OP_PUSH: begin
        ram_addr = ptr_up;
        ram_we   = 1'b1;
        ptr_nxt  = ptr_up;
        ovf_hit  = (ptr_q == PTR_TOP);
      end
      OP_POP: begin
        ram_re  = 1'b1;
        ptr_nxt = ptr_dn;
        unf_hit = (ptr_q == '0);
      end
      OP_INDEXED: begin
        ram_addr = idx;
        ram_we   = wr;
        ram_re   = rd;
      end
      default: ;
    endcase
    // Load only redirects the pointer; the RAM access above keeps the old one.
    if (reset && ptr_ld) ptr_nxt = ptr_din;
  end

  pdl_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .rd_old(ram_rd_old),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Pointer, read-valid pulse and the post-reset zero mask for pdlo.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      ptr_q   <= ptr_nxt;
      valid_q <= ram_re;
      if (ram_re) zero_q <= 1'b0;
    end
  end

  // The RAM read register has no reset, so pdlo reads zero until the first read.
  assign pdlo       = zero_q ? '0 : ram_rdata;
  assign pdlo_valid = valid_q;
  assign pdl_ptr    = ptr_q;

`ifdef PDL_BOUNDS_CHECK_EN
  logic ovf_q;
  logic unf_q;

  // Sticky bounds flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_hit)      ovf_q <= 1'b1;
      else if (err_clr) ovf_q <= 1'b0;
      if (unf_hit)      unf_q <= 1'b1;
      else if (err_clr) unf_q <= 1'b0;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_bounds;
  assign unused_bounds = ^{ovf_hit, unf_hit, err_clr};
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pdl_stack.sv
// Scoreboard bench for pdl_stack: a behavioural model queues expected read data
// as stimulus is applied; each scenario task compares DUT outputs inline.
module tb_pdl_stack;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] l;
  logic          push, pop, rd, wr, ptr_ld, err_clr;
  logic [AW-1:0] idx, ptr_din;
  logic [DW-1:0] pdlo;
  logic          pdlo_valid;
  logic [AW-1:0] pdl_ptr;
  logic          overflow, underflow;

  pdl_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .l(l), .push(push), .pop(pop), .rd(rd), .wr(wr),
    .idx(idx), .ptr_ld(ptr_ld), .ptr_din(ptr_din), .err_clr(err_clr),
    .pdlo(pdlo), .pdlo_valid(pdlo_valid), .pdl_ptr(pdl_ptr),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

`ifdef PDL_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic [DW-1:0] m_mem [16];
  logic [AW-1:0] m_ptr;
  logic [DW-1:0] m_pdlo;
  logic          m_ovf, m_unf;
  bit            exp_v;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] e;
  int            n_checks = 0;
  int            n_fail = 0;

  // Apply current inputs to the model, queue any expected read, clock once.
  task automatic clk_step();
    logic [AW-1:0] np;
    bit so, su;
    exp_v = 1'b0;
    so = 1'b0;
    su = 1'b0;
    if (!reset) begin
      m_ptr = '0; m_pdlo = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      np = m_ptr;
      if (push && pop) begin
        exp_v = 1'b1; m_pdlo = m_mem[m_ptr]; m_mem[m_ptr] = l;
      end else if (push) begin
        np = m_ptr + 4'd1; m_mem[np] = l; so = (m_ptr == 4'hF);
      end else if (pop) begin
        exp_v = 1'b1; m_pdlo = m_mem[m_ptr]; np = m_ptr - 4'd1; su = (m_ptr == 4'h0);
      end else begin
        if (wr) m_mem[idx] = l;
        if (rd) begin exp_v = 1'b1; m_pdlo = m_mem[idx]; end
      end
      if (ptr_ld) np = ptr_din;
      m_ptr = np;
      if (CHK) begin
        if (err_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (so) m_ovf = 1'b1;
        if (su) m_unf = 1'b1;
      end
    end
    if (exp_v) exp_q.push_back(m_pdlo);
    @(posedge clk);
    #1;
    push = 0; pop = 0; rd = 0; wr = 0; ptr_ld = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push = 1'b1; l = 32'h5;
    clk_step();
    push = 1'b1; wr = 1'b1; idx = 4'd3;
    clk_step();
    n_checks++;
    if ({pdl_ptr, pdlo, pdlo_valid, overflow, underflow} !== {4'h0, 32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state got ptr=%0h pdlo=%0h v=%0b ovf=%0b unf=%0b exp all zero",
               pdl_ptr, pdlo, pdlo_valid, overflow, underflow);
    end
    reset = 1'b1;
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; l = vals[i];
      clk_step();
    end
    n_checks++;
    if (pdl_ptr !== 4'd3) begin
      n_fail++; $display("FAIL push_ptr got=%0d exp=3", pdl_ptr);
    end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      clk_step();
      e = exp_q.pop_front();
      n_checks++;
      if (pdlo_valid !== 1'b1 || pdlo !== e || pdlo !== vals[2-i]) begin
        n_fail++;
        $display("FAIL pop_data got v=%0b d=%0h exp v=1 d=%0h", pdlo_valid, pdlo, vals[2-i]);
      end
    end
    n_checks++;
    if (pdl_ptr !== 4'd0) begin
      n_fail++; $display("FAIL pop_ptr got=%0d exp=0", pdl_ptr);
    end
    clk_step();
    n_checks++;
    if (pdlo_valid !== 1'b0 || pdlo !== 32'h11) begin
      n_fail++; $display("FAIL idle_hold got v=%0b d=%0h exp v=0 d=11", pdlo_valid, pdlo);
    end
  endtask

  task automatic test_replace();
    ptr_ld = 1'b1; ptr_din = 4'd4;
    clk_step();
    push = 1'b1; l = 32'h55;
    clk_step();
    push = 1'b1; pop = 1'b1; l = 32'hAA;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo_valid !== 1'b1 || pdlo !== e || pdl_ptr !== 4'd5 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL replace_top got v=%0b d=%0h ptr=%0d exp v=1 d=%0h ptr=5", pdlo_valid, pdlo, pdl_ptr, e);
    end
    pop = 1'b1;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo !== e || pdl_ptr !== 4'd4) begin
      n_fail++; $display("FAIL replace_pop got d=%0h ptr=%0d exp d=%0h ptr=4", pdlo, pdl_ptr, e);
    end
  endtask

  task automatic test_indexed();
    wr = 1'b1; rd = 1'b1; idx = 4'd7; l = 32'hBEEF;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo_valid !== 1'b1 || pdlo !== e) begin
      n_fail++; $display("FAIL rdwr_first got v=%0b d=%0h exp v=1 d=%0h", pdlo_valid, pdlo, e);
    end
    wr = 1'b1; idx = 4'd8; l = 32'h1234;
    clk_step();
    n_checks++;
    if (pdlo_valid !== 1'b0 || pdlo !== m_pdlo) begin
      n_fail++; $display("FAIL wr_only got v=%0b d=%0h exp v=0 d=%0h", pdlo_valid, pdlo, m_pdlo);
    end
    rd = 1'b1; idx = 4'd7;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo !== e) begin
      n_fail++; $display("FAIL rd_later got=%0h exp=%0h", pdlo, e);
    end
    wr = 1'b1; idx = 4'd9; l = 32'hCAFE;
    clk_step();
    rd = 1'b1; idx = 4'd9;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo_valid !== 1'b1 || pdlo !== e) begin
      n_fail++; $display("FAIL rd_after_wr got v=%0b d=%0h exp d=%0h", pdlo_valid, pdlo, e);
    end
  endtask

  task automatic test_priority();
    push = 1'b1; rd = 1'b1; idx = 4'd2; l = 32'h77;
    clk_step();
    n_checks++;
    if (pdlo_valid !== 1'b0 || pdl_ptr !== m_ptr) begin
      n_fail++; $display("FAIL push_over_rd got v=%0b ptr=%0d exp v=0 ptr=%0d", pdlo_valid, pdl_ptr, m_ptr);
    end
    pop = 1'b1; wr = 1'b1; idx = 4'd7; l = 32'hDEAD;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo !== e) begin
      n_fail++; $display("FAIL pop_over_wr got=%0h exp=%0h", pdlo, e);
    end
    rd = 1'b1; idx = 4'd7;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo !== e) begin
      n_fail++; $display("FAIL wr_dropped got=%0h exp=%0h", pdlo, e);
    end
  endtask

  task automatic test_bounds();
    ptr_ld = 1'b1; ptr_din = 4'hF;
    clk_step();
    push = 1'b1; l = 32'h1;
    clk_step();
    n_checks++;
    if (pdl_ptr !== 4'd0 || overflow !== CHK || underflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_wrap got ptr=%0d ovf=%0b exp ptr=0 ovf=%0b", pdl_ptr, overflow, CHK);
    end
    err_clr = 1'b1;
    clk_step();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL err_clr got ovf=%0b exp=0", overflow);
    end
    ptr_ld = 1'b1; ptr_din = 4'hF;
    clk_step();
    push = 1'b1; err_clr = 1'b1; l = 32'h1;
    clk_step();
    n_checks++;
    if (overflow !== m_ovf || overflow !== CHK) begin
      n_fail++; $display("FAIL set_wins got ovf=%0b exp=%0b", overflow, CHK);
    end
    err_clr = 1'b1;
    clk_step();
    pop = 1'b1;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo !== e || pdlo !== 32'h1 || pdl_ptr !== 4'hF || underflow !== CHK) begin
      n_fail++;
      $display("FAIL underflow_wrap got d=%0h ptr=%0h unf=%0b exp d=1 ptr=f unf=%0b", pdlo, pdl_ptr, underflow, CHK);
    end
    reset = 1'b0; pop = 1'b1;
    clk_step();
    n_checks++;
    if (pdlo_valid !== 1'b0 || pdlo !== 32'h0 || pdl_ptr !== 4'h0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard got v=%0b d=%0h ptr=%0h unf=%0b exp all zero", pdlo_valid, pdlo, pdl_ptr, underflow);
    end
    reset = 1'b1;
    ptr_ld = 1'b1; ptr_din = 4'd2; push = 1'b1; l = 32'h99;
    clk_step();
    n_checks++;
    if (pdl_ptr !== 4'd2) begin
      n_fail++; $display("FAIL ld_over_push got ptr=%0d exp=2", pdl_ptr);
    end
    rd = 1'b1; idx = 4'd1;
    clk_step();
    e = exp_q.pop_front();
    n_checks++;
    if (pdlo !== e || pdlo !== 32'h99) begin
      n_fail++; $display("FAIL ld_push_addr got=%0h exp=99", pdlo);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; idx = 4'(i); l = 32'h1000 + 32'(i);
      clk_step();
    end
    for (int i = 0; i < 48; i++) begin
      {push, pop, rd, wr} = 4'($urandom_range(0, 15));
      ptr_ld = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 3) == 0);
      idx = 4'($urandom_range(0, 15));
      ptr_din = 4'($urandom_range(0, 15));
      l = $urandom;
      clk_step();
      n_checks++;
      if (exp_v) begin
        e = exp_q.pop_front();
        if (pdlo_valid !== 1'b1 || pdlo !== e || {pdl_ptr, overflow, underflow} !== {m_ptr, m_ovf, m_unf}) begin
          n_fail++;
          $display("FAIL b2b_read[%0d] got v=%0b d=%0h ptr=%0h f=%0b%0b exp d=%0h ptr=%0h f=%0b%0b",
                   i, pdlo_valid, pdlo, pdl_ptr, overflow, underflow, e, m_ptr, m_ovf, m_unf);
        end
      end else begin
        if (pdlo_valid !== 1'b0 || pdlo !== m_pdlo || {pdl_ptr, overflow, underflow} !== {m_ptr, m_ovf, m_unf}) begin
          n_fail++;
          $display("FAIL b2b_idle[%0d] got v=%0b d=%0h ptr=%0h f=%0b%0b exp v=0 d=%0h ptr=%0h f=%0b%0b",
                   i, pdlo_valid, pdlo, pdl_ptr, overflow, underflow, m_pdlo, m_ptr, m_ovf, m_unf);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; l = '0; push = 0; pop = 0; rd = 0; wr = 0;
    ptr_ld = 0; err_clr = 0; idx = '0; ptr_din = '0;
    m_ptr = '0; m_pdlo = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    test_reset();
    test_push_pop();
    test_replace();
    test_indexed();
    test_priority();
    test_bounds();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0 entries", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pdl_stack.md
PDL_STACK -- requirements
Module: pdl_stack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port l  input  DATA_WIDTH  write data for push/wr.
REQ-006 SHALL have port push  input  1  write l at pdl_ptr+1; pointer increments.
REQ-007 SHALL have port pop  input  1  read at pdl_ptr; pointer decrements.
REQ-008 SHALL have port rd  input  1  indexed read at idx.
REQ-009 SHALL have port wr  input  1  indexed write of l at idx.
REQ-010 SHALL have port idx  input  ADDR_WIDTH  indexed-access address.
REQ-011 SHALL have port ptr_ld  input  1  load pointer from ptr_din.
REQ-012 SHALL have port ptr_din  input  ADDR_WIDTH  pointer load value.
REQ-013 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-014 SHALL have port pdlo  output  DATA_WIDTH  read data.
REQ-015 SHALL have port pdlo_valid  output  1  one-cycle pulse, pdlo updated.
REQ-016 SHALL have port pdl_ptr  output  ADDR_WIDTH  current stack pointer.
REQ-017 SHALL have ports overflow, underflow  output  1 each  sticky bounds errors.

Function
REQ-018 Read latency SHALL be 1 cycle: pop/rd in cycle N -> pdlo, pdlo_valid=1 in N+1; otherwise pdlo holds, pdlo_valid=0.
REQ-019 Push SHALL write ram[pdl_ptr+1] <= l and set pdl_ptr <= pdl_ptr+1.
REQ-020 Pop SHALL return ram[pdl_ptr] and set pdl_ptr <= pdl_ptr-1.
REQ-021 Push and pop together SHALL replace top: ram[pdl_ptr] <= l, pdlo <= old ram[pdl_ptr], pointer unchanged, no error flag.
REQ-022 Any push/pop SHALL take priority over rd/wr; rd/wr in that cycle are dropped.
REQ-023 rd and wr together SHALL be write-first: ram[idx] <= l, pdlo <= l.
REQ-024 A read of an address written the previous cycle SHALL return the new data.
REQ-025 ptr_ld SHALL override the pointer update of push/pop; the push/pop RAM access still uses the pre-load pointer.
REQ-026 Pointer arithmetic SHALL be modulo 2**ADDR_WIDTH (push at all-ones wraps to 0; pop at 0 wraps to all-ones).

Reset
REQ-027 While reset=0: pdl_ptr=0, pdlo=0, pdlo_valid=0, overflow=0, underflow=0; all requests, including RAM writes, ignored.
REQ-028 RAM contents SHALL NOT be cleared by reset; a read pending when reset asserts SHALL be discarded.

Configuration
REQ-029 Macro PDL_BOUNDS_CHECK_EN defined: push alone at pdl_ptr=all-ones sets overflow; pop alone at pdl_ptr=0 sets underflow; flags sticky until err_clr; set wins over same-cycle clear.
REQ-030 Macro PDL_BOUNDS_CHECK_EN undefined: overflow and underflow SHALL be constant 0; wrap behaviour per REQ-026 unchanged.

Structure
REQ-031 Package pdl_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and the pointer-increment/decrement helper functions.
REQ-032 Storage SHALL be one sub-module pdl_ram: synchronous single-port, write-first, DATA_WIDTH x 2**ADDR_WIDTH, no reset.

Verification
REQ-033 Reset, push l=0x11,0x22,0x33 -> pdl_ptr=3; pop x3 -> pdlo 0x33,0x22,0x11 one cycle after each pop, pdl_ptr=0.
REQ-034 pdl_ptr=5, push+pop l=0xAA where ram[5]=0x55 -> pdlo=0x55, pdl_ptr=5; next pop -> 0xAA.
REQ-035 wr idx=7 l=0xBEEF with rd idx=7 -> pdlo=0xBEEF next cycle; rd idx=7 alone later -> 0xBEEF.
REQ-036 ptr_ld ptr_din=all-ones, push l=1 (EN defined) -> pdl_ptr=0, overflow=1, ram[0]=1; err_clr -> overflow=0; EN undefined -> overflow stays 0.
REQ-037 pop at pdl_ptr=0 (EN defined) -> underflow=1, pdl_ptr=all-ones; pop with reset=0 next cycle -> pdlo_valid=0, pdlo=0, pdl_ptr=0.
REQ-038 push with rd idx=2 same cycle -> push executes, no pdlo_valid pulse from rd.
